// File: rtl/mac_pkg.sv
// Shared definitions for the MAC family: accumulator width derivation,
// saturation limits and the per-stage framing record.
package mac_pkg;

  // Widest accumulator any helper below is asked to describe.
  localparam int MAC_MAX_W = 256;

  typedef struct packed {
    logic valid;
    logic last;
  } mac_stage_t;

  function automatic int acc_w(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  function automatic logic [MAC_MAX_W-1:0] sat_max_u(input int w);
    return {MAC_MAX_W{1'b1}} >> (MAC_MAX_W - w);
  endfunction

  function automatic logic [MAC_MAX_W-1:0] sat_min_u(input int w);
    return {MAC_MAX_W{1'b0}} & ({MAC_MAX_W{1'b1}} >> (MAC_MAX_W - w));
  endfunction

  function automatic logic [MAC_MAX_W-1:0] sat_max_s(input int w);
    return {MAC_MAX_W{1'b1}} >> (MAC_MAX_W - w + 1);
  endfunction

  function automatic logic [MAC_MAX_W-1:0] sat_min_s(input int w);
    return {{(MAC_MAX_W-1){1'b0}}, 1'b1} << (w - 1);
  endfunction

endpackage

// File: rtl/mac_sat_add.sv
// Combinational W-bit adder with overflow detection and optional clamping,
// signed or unsigned; shared by accumulators and adder trees.
module mac_sat_add
  import mac_pkg::*;
#(
  parameter int W        = 40,
  parameter bit SIGNED   = 1'b0,
  parameter bit SATURATE = 1'b1
) (
  input  logic [W-1:0] acc,
  input  logic [W-1:0] addend,
  output logic [W-1:0] sum,
  output logic         ovf
);

  localparam logic [W-1:0] MAX_U = W'(sat_max_u(W));
  localparam logic [W-1:0] MAX_S = W'(sat_max_s(W));
  localparam logic [W-1:0] MIN_S = W'(sat_min_s(W));

  logic [W:0] wide_sum;

  // Signed overflow shows as disagreement between the guard bit and the MSB.
  always_comb begin
    if (SIGNED) begin
      wide_sum = {acc[W-1], acc} + {addend[W-1], addend};
      ovf      = wide_sum[W] ^ wide_sum[W-1];
    end else begin
      wide_sum = {1'b0, acc} + {1'b0, addend};
      ovf      = wide_sum[W];
    end

    if (ovf && SATURATE) begin
      if (SIGNED) begin
        sum = wide_sum[W] ? MIN_S : MAX_S;
      end else begin
        sum = MAX_U;
      end
    end else begin
      sum = wide_sum[W-1:0];
    end
  end

endmodule

// File: rtl/mac_acc_pipe.sv
// Three-stage multiply-accumulate: operand register, product register, then
// accumulator with valid/last framing that emits one result per vector.
module mac_acc_pipe
  import mac_pkg::*;
#(
  parameter int  WIDTH    = 16,
  parameter int  GUARD    = 8,
  parameter bit  SIGNED   = 1'b0,
  parameter bit  SATURATE = 1'b1,
  parameter int  CNT_W    = 16,
  localparam int ACC_W    = acc_w(WIDTH, GUARD)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             last,
  input  logic             flush,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  mac_stage_t s1_q, s1_d, s2_q, s2_d;
  logic [WIDTH-1:0]          a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]          prod_q, prod_d, acc_q, acc_d, out_data_q, out_data_d;
  logic                      ovf_q, ovf_d, out_ovf_q, out_ovf_d, out_valid_q, out_valid_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d, out_count_q, out_count_d, cnt_inc;
  logic [ACC_W-1:0]          sum;
  logic                      sum_ovf;
  logic signed [2*WIDTH-1:0] prod_signed;
  logic [2*WIDTH-1:0]        prod_unsigned;

  mac_sat_add #(
    .W        (ACC_W),
    .SIGNED   (SIGNED),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .acc    (acc_q),
    .addend (prod_q),
    .sum    (sum),
    .ovf    (sum_ovf)
  );

  // Operands are widened before multiplying so the product is exact in 2*WIDTH bits.
  always_comb begin
    s1_d.valid    = in_valid & ~flush;
    s1_d.last     = in_valid & last;
    a_d           = a;
    b_d           = b;
    s2_d.valid    = s1_q.valid & ~flush;
    s2_d.last     = s1_q.last;
    prod_signed   = $signed({{WIDTH{a_q[WIDTH-1]}}, a_q}) * $signed({{WIDTH{b_q[WIDTH-1]}}, b_q});
    prod_unsigned = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    if (SIGNED) begin
      prod_d = ACC_W'(prod_signed);
    end else begin
      prod_d = ACC_W'(prod_unsigned);
    end
  end

  assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

  // A last beat publishes the post-update totals and reopens the vector in the same edge.
  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    out_count_d = out_count_q;
    out_valid_d = 1'b0;
    if (flush) begin
      acc_d = {ACC_W{1'b0}};
      ovf_d = 1'b0;
      cnt_d = {CNT_W{1'b0}};
    end else if (s2_q.valid) begin
      if (s2_q.last) begin
        out_data_d  = sum;
        out_ovf_d   = ovf_q | sum_ovf;
        out_count_d = cnt_inc;
        out_valid_d = 1'b1;
        acc_d       = {ACC_W{1'b0}};
        ovf_d       = 1'b0;
        cnt_d       = {CNT_W{1'b0}};
      end else begin
        acc_d = sum;
        ovf_d = ovf_q | sum_ovf;
        cnt_d = cnt_inc;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= '{valid: 1'b0, last: 1'b0};
      s2_q        <= '{valid: 1'b0, last: 1'b0};
      a_q         <= {WIDTH{1'b0}};
      b_q         <= {WIDTH{1'b0}};
      prod_q      <= {ACC_W{1'b0}};
      acc_q       <= {ACC_W{1'b0}};
      ovf_q       <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      out_data_q  <= {ACC_W{1'b0}};
      out_ovf_q   <= 1'b0;
      out_count_q <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      a_q         <= a_d;
      b_q         <= b_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_count = out_count_q;
  assign busy      = s1_q.valid | s2_q.valid | (cnt_q != {CNT_W{1'b0}});

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Directed bench: one 16-bit unsigned saturating MAC plus two 4-bit signed
// MACs (saturating and wrapping) driven with hand-computed vectors.
module tb_mac_acc_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;

  logic        v16 = 1'b0, l16 = 1'b0;
  logic [15:0] a16 = 16'd0, b16 = 16'd0;
  logic        ov16, oo16, busy16;
  logic [39:0] od16;
  logic [15:0] oc16;

  logic        v4 = 1'b0, l4 = 1'b0;
  logic [3:0]  a4 = 4'd0, b4 = 4'd0;
  logic        ovs, oos, bsys, ovw, oow, bsyw;
  logic [7:0]  ods, odw;
  logic [15:0] ocs, ocw;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  mac_acc_pipe u_u16 (
    .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .last(l16), .flush(flush),
    .out_valid(ov16), .out_data(od16), .out_ovf(oo16), .out_count(oc16), .busy(busy16)
  );

  mac_acc_pipe #(.WIDTH(4), .GUARD(0), .SIGNED(1'b1), .SATURATE(1'b1)) u_s4_sat (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .last(l4), .flush(flush),
    .out_valid(ovs), .out_data(ods), .out_ovf(oos), .out_count(ocs), .busy(bsys)
  );

  mac_acc_pipe #(.WIDTH(4), .GUARD(0), .SIGNED(1'b1), .SATURATE(1'b0)) u_s4_wrap (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .last(l4), .flush(flush),
    .out_valid(ovw), .out_data(odw), .out_ovf(oow), .out_count(ocw), .busy(bsyw)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat16(input logic [15:0] x, input logic [15:0] y, input logic l);
    a16 = x; b16 = y; l16 = l; v16 = 1'b1;
    tick();
    v16 = 1'b0; l16 = 1'b0;
  endtask

  task automatic beat4(input logic [3:0] x, input logic [3:0] y, input logic l);
    a4 = x; b4 = y; l4 = l; v4 = 1'b1;
    tick();
    v4 = 1'b0; l4 = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("rst_valid", {63'd0, ov16}, 64'd0);
    check("rst_data",  {24'd0, od16}, 64'd0);
    check("rst_count", {48'd0, oc16}, 64'd0);
    check("rst_busy",  {63'd0, busy16}, 64'd0);

    // 3*4 + 5*6 + 7*8 with an idle cycle inside the vector
    beat16(16'd3, 16'd4, 1'b0);
    tick();
    beat16(16'd5, 16'd6, 1'b0);
    beat16(16'd7, 16'd8, 1'b1);
    check("t1_busy", {63'd0, busy16}, 64'd1);
    tick();
    check("t1_early", {63'd0, ov16}, 64'd0);
    tick();
    check("t1_valid", {63'd0, ov16}, 64'd1);
    check("t1_data",  {24'd0, od16}, 64'd98);
    check("t1_count", {48'd0, oc16}, 64'd3);
    check("t1_ovf",   {63'd0, oo16}, 64'd0);
    tick();
    check("t1_pulse", {63'd0, ov16}, 64'd0);
    check("t1_idle",  {63'd0, busy16}, 64'd0);

    // back-to-back single-term vectors
    beat16(16'd2, 16'd2, 1'b1);
    beat16(16'd3, 16'd3, 1'b1);
    tick();
    check("b2b_v1",    {63'd0, ov16}, 64'd1);
    check("b2b_d1",    {24'd0, od16}, 64'd4);
    check("b2b_c1",    {48'd0, oc16}, 64'd1);
    tick();
    check("b2b_v2",    {63'd0, ov16}, 64'd1);
    check("b2b_d2",    {24'd0, od16}, 64'd9);
    tick();
    check("b2b_end",   {63'd0, ov16}, 64'd0);

    // flush drops in-flight beats and the beat presented with it
    beat16(16'd10, 16'd10, 1'b0);
    beat16(16'd10, 16'd10, 1'b0);
    flush = 1'b1; a16 = 16'd1; b16 = 16'd1; v16 = 1'b1;
    tick();
    flush = 1'b0; v16 = 1'b0;
    check("fl_valid", {63'd0, ov16}, 64'd0);
    check("fl_hold",  {24'd0, od16}, 64'd9);
    check("fl_busy",  {63'd0, busy16}, 64'd0);
    beat16(16'd5, 16'd5, 1'b1);
    tick();
    tick();
    check("fl_v",     {63'd0, ov16}, 64'd1);
    check("fl_data",  {24'd0, od16}, 64'd25);
    check("fl_count", {48'd0, oc16}, 64'd1);
    check("fl_ovf",   {63'd0, oo16}, 64'd0);

    // signed 4-bit: (-8*-8) twice = 128 exceeds int8
    beat4(4'h8, 4'h8, 1'b0);
    beat4(4'h8, 4'h8, 1'b1);
    tick();
    tick();
    check("s_sat_v",    {63'd0, ovs}, 64'd1);
    check("s_sat_data", {56'd0, ods}, 64'h7F);
    check("s_sat_ovf",  {63'd0, oos}, 64'd1);
    check("s_sat_cnt",  {48'd0, ocs}, 64'd2);
    check("s_wrap_v",   {63'd0, ovw}, 64'd1);
    check("s_wrap_data",{56'd0, odw}, 64'h80);
    check("s_wrap_ovf", {63'd0, oow}, 64'd1);
    tick();

    // 300 x 0xFFFF*0xFFFF saturates the 40-bit accumulator
    for (int i = 0; i < 299; i++) begin
      beat16(16'hFFFF, 16'hFFFF, 1'b0);
    end
    beat16(16'hFFFF, 16'hFFFF, 1'b1);
    tick();
    tick();
    check("max_v",     {63'd0, ov16}, 64'd1);
    check("max_data",  {24'd0, od16}, 64'h00FF_FFFF_FFFF);
    check("max_ovf",   {63'd0, oo16}, 64'd1);
    check("max_count", {48'd0, oc16}, 64'd300);
    tick();

    // reset with a last beat still in the pipe
    beat16(16'd1, 16'd1, 1'b0);
    beat16(16'd2, 16'd2, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rr_valid", {63'd0, ov16}, 64'd0);
    check("rr_data",  {24'd0, od16}, 64'd0);
    check("rr_ovf",   {63'd0, oo16}, 64'd0);
    check("rr_count", {48'd0, oc16}, 64'd0);
    check("rr_busy",  {63'd0, busy16}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rr_quiet", {63'd0, ov16}, 64'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mac_acc_pipe.md
# mac_acc_pipe

Parametrised, pipelined multiply-accumulate unit: next generation of the 16-bit MAC, which combined a combinational multiplier, a 32-bit adder and a free-running accumulator register. Adds:
- generic operand width and guard bits;
- a signed/unsigned mode;
- optional saturation with a sticky overflow flag;
- a valid/last framing handshake that returns one dot-product result per vector and restarts accumulation automatically.

It sits between operand sources (filter taps, matrix rows) and result consumers in the MAC datapath.

## Interface
Parameters:
- WIDTH, 16, operand width of a and b.
- GUARD, 8, extra accumulator bits above the 2*WIDTH product; ACC_W = 2*WIDTH+GUARD.
- SIGNED, 0, 1 = two's-complement operands and accumulator, 0 = unsigned.
- SATURATE, 1, 1 = clamp on overflow, 0 = wrap modulo 2^ACC_W.
- CNT_W, 16, width of the term counter.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset is synchronous and active-high.
- in_valid  in  1  a/b/last are valid this cycle; beat accepted unconditionally (no backpressure).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- last  in  1  beat is the final term of the current vector; sampled only with in_valid.
- flush  in  1  abort: clears accumulator and in-flight beats.
- out_valid  out  1  one-cycle pulse: out_data/out_ovf/out_count hold a completed vector result.
- out_data  out  ACC_W  accumulated result.
- out_ovf  out  1  overflow occurred at any point in this vector.
- out_count  out  CNT_W  number of terms in this vector; saturates at all-ones.
- busy  out  1  any beat in flight or accumulation open (acc_count != 0).

## Operation
- Stage S1 registers a, b, valid and last.
- Stage S2 registers the full-precision product: signed or unsigned per SIGNED, sign- or zero-extended to ACC_W.
- Stage S3 holds the internal accumulator acc, ovf and cnt. On an S2 valid beat:
  - sum = acc + product, computed at ACC_W+1 bits.
  - Overflow: sum outside the ACC_W range (signed or unsigned as configured).
  - SATURATE=1: acc clamps to the max/min representable value. Signed max/min are 2^(ACC_W-1)-1 and -2^(ACC_W-1); unsigned max is 2^ACC_W-1.
  - SATURATE=0: acc takes the low ACC_W bits.
  - Overflow sets ovf in both modes.
  - cnt increments, holding at all-ones.
- S2 beat with last=1:
  - out_data, out_ovf and out_count register the post-update values; out_valid=1 for that cycle.
  - acc, ovf and cnt return to 0 in the same edge, so the next beat starts a new vector.
- Saturation is sticky within a vector: later terms add to the clamped value.
- flush=1 at an edge:
  - acc, ovf, cnt and all stage valids clear; out_valid=0.
  - out_data, out_ovf and out_count hold their last values.
  - Flush wins over in_valid in the same cycle; that beat is dropped.
- rst has the same effect as flush and additionally clears out_data, out_ovf and out_count.
- Reset values of every output: out_valid 0, out_data 0, out_ovf 0, out_count 0, busy 0.

## Timing
- Latency: a beat accepted at edge k (in_valid high in the preceding cycle) updates acc at edge k+2. If it carries last, out_valid is high in the cycle after edge k+2, i.e. 3 cycles after presentation.
- Throughput: one beat per cycle sustained. Back-to-back vectors need no idle cycle: a last beat may be followed immediately by the first beat of the next vector.
- A single-term vector (last on the first beat) gives out_count=1 and out_data equal to the product.
- flush mid-vector discards beats currently in S1/S2; beats presented after the flush edge start a fresh vector.
- Gaps in in_valid are allowed and leave acc unchanged.

## Structure
- Shared package mac_pkg holds:
  - the ACC_W derivation function;
  - saturation-limit helper functions (max/min for signed and unsigned);
  - a stage record typedef {valid, last}, reused by other MAC variants.
- One natural sub-module, mac_sat_add: a combinational ACC_W adder with saturation and overflow detection, parametrised by SIGNED and SATURATE, reused by future adder-tree blocks.
- The multiplier is an inferred `*` in S2. Wallace or Kogge-Stone substitution is a later drop-in behind the same S2 register boundary.

## Test plan
- Unsigned, WIDTH=16: beats (3,4),(5,6),(7,8,last) -> out_valid 3 cycles after the last beat, out_data=98, out_count=3, out_ovf=0.
- Signed, WIDTH=4, GUARD=0, SATURATE=1: (-8,-8),(-8,-8,last) -> out_data=127, out_ovf=1. Same with SATURATE=0 -> out_data=-128 (0x80), out_ovf=1.
- Back-to-back vectors, WIDTH=16: (2,2,last) then (3,3,last) on consecutive cycles -> two consecutive out_valid pulses with values 4 and 9; the second vector does not include the first.
- Flush mid-vector: (10,10),(10,10) then flush with (1,1) presented, then (5,5,last) -> out_data=25, out_count=1.
- Unsigned max operands 0xFFFF*0xFFFF repeated 300 times with GUARD=8 -> saturates at 2^40-1, out_ovf=1, out_count=300.
- rst asserted mid-vector with last in flight -> no out_valid; all outputs 0 the cycle after the reset edge; busy=0.
